// File: rtl/dsram_pkg.sv
// Shared definitions for the data-SRAM responder: FSM states, word geometry,
// and the lane write-enable helper.
package dsram_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dsram_state_e;

  // Byte-lane write enables: requested strobes, qualified by a commit condition.
  function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [WORD_BYTES-1:0] we,
                                                      input logic                  commit);
    return we & {WORD_BYTES{commit}};
  endfunction

endpackage

// File: rtl/dsram_bank.sv
// Word-organised RAM with per-byte write enables and a synchronous, read-enabled
// output register. No reset, so it maps onto block RAM.
module dsram_bank
  import dsram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [WORD_BYTES-1:0] i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];
  logic [31:0] r_q;

  // Lane-masked write and read-enabled registered read; q holds between loads.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM interface: byte-strobed loads/stores on an
// internal word RAM, optional wait states with a pipeline stall request.
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic        addr_err
);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic        w_fire;
  logic        w_stall;
  logic [3:0]  w_we;
  logic [29:0] w_waddr;
  logic [31:0] w_wdata;
  logic [29:0] w_word_off;
  logic        w_in_range;
  logic        w_load;
  logic [3:0]  w_bank_we;
  logic        w_bank_re;
  logic [31:0] w_bank_q;
  logic        r_resp;
  logic        r_err;
  logic        r_zero;

  // Reset synchroniser: asserts asynchronously, releases on the clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  if (WAIT_CYCLES == 0) begin : g_direct
    assign w_fire  = data_sram_en & w_rst_n;
    assign w_we    = data_sram_we;
    assign w_waddr = data_sram_addr[31:2];
    assign w_wdata = data_sram_wdata;
    assign w_stall = 1'b0;
  end else begin : g_fsm
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    dsram_state_e r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_capture;
    logic          w_stall_fsm;
    logic          w_done;
    logic [3:0]    r_we;
    logic [29:0]   r_waddr;
    logic [31:0]   r_wdata;

    // State, wait counter and captured request; the access runs from the copy.
    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_we    <= '0;
        r_waddr <= '0;
        r_wdata <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        if (w_capture) begin
          r_we    <= data_sram_we;
          r_waddr <= data_sram_addr[31:2];
          r_wdata <= data_sram_wdata;
        end
      end
    end

    // Next state and stall: stall from the request cycle until DONE, commit on DONE exit.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_stall_fsm = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (data_sram_en) begin
            w_stall_fsm = 1'b1;
            w_capture   = 1'b1;
            w_cnt_nxt   = CW'(WAIT_CYCLES - 1);
            w_state_nxt = (WAIT_CYCLES == 1) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          w_stall_fsm = 1'b1;
          w_cnt_nxt   = r_cnt - CW'(1);
          if (w_cnt_nxt == '0) w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Request may be held high through reset; stall only once the block is live.
    assign w_stall = w_stall_fsm & w_rst_n;
    assign w_fire  = w_done;
    assign w_we    = r_we;
    assign w_waddr = r_waddr;
    assign w_wdata = r_wdata;
  end

  // Word offset from the base; anything at or beyond the RAM size (or below base,
  // which wraps to a large value) is out of range.
  assign w_word_off = w_waddr - BASE_ADDR[31:2];
  assign w_in_range = (w_word_off >> DEPTH_LOG2) == '0;
  assign w_load     = (w_we == 4'b0000);
  assign w_bank_we  = lane_mask(w_we, w_fire & w_in_range);
  assign w_bank_re  = w_fire & w_load & w_in_range;

  dsram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_bank_we),
    .i_re    (w_bank_re),
    .i_addr  (w_word_off[DEPTH_LOG2-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_bank_q)
  );

  // Response pulses, plus a flag that forces rdata to zero after reset or an
  // out-of-range load; the bank output register itself holds the last good load.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_resp <= 1'b0;
      r_err  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_resp <= w_fire;
      r_err  <= w_fire & ~w_in_range;
      if (w_fire & w_load) r_zero <= ~w_in_range;
    end
  end

  assign data_sram_rdata = r_zero ? '0 : w_bank_q;
  assign stallreq        = w_stall;
  assign resp_valid      = r_resp;
  assign addr_err        = r_err;

endmodule
